// File: rtl/apb_req_arbiter_if.sv
// Bus between the request arbiter and the APB_master user port.
// "master" is the arbiter side (it drives the APB_master command inputs),
// "slave" is the APB_master side (it returns read data, valid and busy).
interface apb_req_arbiter_if #(
  parameter int IDX_WIDTH  = 2,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16
);
  logic                  o_enable;
  logic                  o_wr;
  logic [IDX_WIDTH-1:0]  o_slave_idx;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_data_w;
  logic [DATA_WIDTH-1:0] i_data_r;
  logic                  i_data_valid;
  logic                  i_busy;

  modport master (
    output o_enable, o_wr, o_slave_idx, o_addr, o_data_w,
    input  i_data_r, i_data_valid, i_busy
  );

  modport slave (
    input  o_enable, o_wr, o_slave_idx, o_addr, o_data_w,
    output i_data_r, i_data_valid, i_busy
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one APB_master user
// port. One transaction is in flight at a time: grant/ack, one-cycle enable,
// wait for data_valid (or a timeout), one-cycle response, back to idle.
// Every output comes straight from a flop.
module apb_req_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  IDX_WIDTH  = 2,
  parameter int  ADDR_WIDTH = 2,
  parameter int  DATA_WIDTH = 16,
  parameter int  TIMEOUT    = 255,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*IDX_WIDTH-1:0]  i_req_slave_idx,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ack,
  apb_req_arbiter_if.master             apb,
  output logic                          o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_busy
);

  // Wait counter is at least 8 bits, wider only if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Per-requester views of the flat command buses (requester k in slice k).
  logic [NUM_REQ-1:0][IDX_WIDTH-1:0]  w_req_idx;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] w_req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_req_data;

  assign w_req_idx  = i_req_slave_idx;
  assign w_req_addr = i_req_addr;
  assign w_req_data = i_req_data;

  state_t                 r_state, w_state_nxt;
  logic [ID_W-1:0]        r_last,  w_last_nxt;
  logic [ID_W-1:0]        r_gnt,   w_gnt_nxt;
  logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
  logic [NUM_REQ-1:0]     r_ack,   w_ack_nxt;
  logic                   r_en,    w_en_nxt;
  logic                   r_wr,    w_wr_nxt;
  logic [IDX_WIDTH-1:0]   r_idx,   w_idx_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr,  w_addr_nxt;
  logic [DATA_WIDTH-1:0]  r_dw,    w_dw_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic [ID_W-1:0]        r_rsp_id,    w_rsp_id_nxt;
  logic [DATA_WIDTH-1:0]  r_rsp_data,  w_rsp_data_nxt;
  logic                   r_rsp_err,   w_rsp_err_nxt;
  logic                   r_busy,      w_busy_nxt;

  logic                   w_pick_vld;
  logic [ID_W-1:0]        w_pick;
  logic [CNT_W:0]         w_cnt_inc;
  logic                   w_to_hit;

  // Requester index base+off, wrapped into 0..NUM_REQ-1.
  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base,
                                             input int off);
    return ID_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // Round-robin pick: scan from farthest to nearest so the first set bit
  // after last_grant is what survives; last_grant itself ranks lowest.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (i_req[f_wrap(r_last, i)]) begin
        w_pick_vld = 1'b1;
        w_pick     = f_wrap(r_last, i);
      end
    end
  end

  // The counter "hits" TIMEOUT on the TIMEOUT-th wait cycle.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_to_hit  = (w_cnt_inc >= (CNT_W + 1)'(TIMEOUT));

  // Next state and next values of every output register.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_gnt_nxt       = r_gnt;
    w_cnt_nxt       = r_cnt;
    w_ack_nxt       = '0;
    w_en_nxt        = 1'b0;
    w_wr_nxt        = r_wr;
    w_idx_nxt       = r_idx;
    w_addr_nxt      = r_addr;
    w_dw_nxt        = r_dw;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_id_nxt    = '0;
    w_rsp_data_nxt  = '0;
    w_rsp_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!apb.i_busy && w_pick_vld) begin
          w_gnt_nxt         = w_pick;
          w_ack_nxt[w_pick] = 1'b1;
          w_wr_nxt          = i_req_wr[w_pick];
          w_idx_nxt         = w_req_idx[w_pick];
          w_addr_nxt        = w_req_addr[w_pick];
          w_dw_nxt          = w_req_data[w_pick];
          w_state_nxt       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_en_nxt    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats the timeout when both land on the same cycle.
        if (apb.i_data_valid) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_gnt;
          w_rsp_data_nxt  = r_wr ? '0 : apb.i_data_r;
          w_state_nxt     = S_DONE;
        end else if (w_to_hit) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_gnt;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
        end
      end
      S_DONE: begin
        w_last_nxt  = r_gnt;
        w_wr_nxt    = 1'b0;
        w_idx_nxt   = '0;
        w_addr_nxt  = '0;
        w_dw_nxt    = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output registers; reset aborts any transaction without a response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack       <= '0;
      r_en        <= 1'b0;
      r_wr        <= 1'b0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_dw        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ack       <= w_ack_nxt;
      r_en        <= w_en_nxt;
      r_wr        <= w_wr_nxt;
      r_idx       <= w_idx_nxt;
      r_addr      <= w_addr_nxt;
      r_dw        <= w_dw_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_req_ack       = r_ack;
  assign apb.o_enable    = r_en;
  assign apb.o_wr        = r_wr;
  assign apb.o_slave_idx = r_idx;
  assign apb.o_addr      = r_addr;
  assign apb.o_data_w    = r_dw;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_id        = r_rsp_id;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_err       = r_rsp_err;
  assign o_busy          = r_busy;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one APB_master user port.
REQ-002 SHALL have parameter IDX_WIDTH, default 2, slave-index width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 2, APB address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, APB data width.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before forced error completion.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all flops on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port i_req, input, NUM_REQ, per-requester request; held high until acked.
REQ-009 SHALL have port i_req_wr, input, NUM_REQ, per-requester write(1)/read(0).
REQ-010 SHALL have port i_req_slave_idx, input, NUM_REQ*IDX_WIDTH, packed slave index; requester k in slice k.
REQ-011 SHALL have port i_req_addr, input, NUM_REQ*ADDR_WIDTH, packed address.
REQ-012 SHALL have port i_req_data, input, NUM_REQ*DATA_WIDTH, packed write data.
REQ-013 SHALL have port o_req_ack, output, NUM_REQ, one-cycle pulse: command of requester k captured.
REQ-014 SHALL have ports o_enable/o_wr (1), o_slave_idx (IDX_WIDTH), o_addr (ADDR_WIDTH), o_data_w (DATA_WIDTH), outputs, driving APB_master i_enable/i_wr/i_slave_idx/i_addr/i_data_w.
REQ-015 SHALL have ports i_data_r (DATA_WIDTH), i_data_valid (1), i_busy (1), inputs, from APB_master o_data_r/o_data_valid/o_busy.
REQ-016 SHALL have ports o_rsp_valid (1), o_rsp_id ($clog2(NUM_REQ)), o_rsp_data (DATA_WIDTH), o_rsp_err (1), outputs, completion response.
REQ-017 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, all outputs registered.
REQ-019 IDLE: when any i_req bit set and i_busy low, SHALL grant the first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping; capture that requester's wr/idx/addr/data; pulse o_req_ack[g]; go ISSUE.
REQ-020 IDLE with i_busy high SHALL not grant, regardless of i_req.
REQ-021 ISSUE: SHALL hold o_enable high exactly one cycle with captured command on o_wr/o_slave_idx/o_addr/o_data_w; go WAIT.
REQ-022 Command outputs SHALL stay stable from ISSUE until DONE; zero otherwise.
REQ-023 WAIT: on i_data_valid SHALL capture i_data_r (reads) or zero (writes), err=0, go DONE.
REQ-024 WAIT: 8-bit-or-wider counter cleared on entry; when it reaches TIMEOUT without i_data_valid SHALL set err=1, data=0, go DONE.
REQ-025 i_data_valid on the same cycle the counter hits TIMEOUT SHALL win: err=0.
REQ-026 DONE: SHALL pulse o_rsp_valid one cycle with o_rsp_id=g, o_rsp_data, o_rsp_err; update last_grant=g; go IDLE.
REQ-027 i_data_valid outside WAIT SHALL be ignored.
REQ-028 Latency: request sampled at edge N -> o_req_ack and o_enable high after edge N+1 (ack) and N+2 (enable); response 1 cycle after valid completion.
REQ-029 Requester dropping i_req before ack SHALL simply lose arbitration; no partial capture.
REQ-030 Only one transaction outstanding; no request accepted outside IDLE.

Reset
REQ-031 On i_rst high, asynchronously: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), counter=0, all outputs 0.
REQ-032 Reset mid-transaction SHALL abort it with no o_rsp_valid; first post-reset grant follows REQ-031 priority.

Verification
REQ-033 Single read: i_req=0001, addr=2, wr=0; APB_master returns i_data_valid with 0x1234 after 3 cycles -> ack[0], one o_enable pulse, o_rsp_valid with id=0, data=0x1234, err=0.
REQ-034 Fairness: i_req=1111 held, each acked and released on ack -> grant order 0,1,2,3, then 0 again after re-request.
REQ-035 Timeout: write issued, i_data_valid never asserted -> o_rsp_valid with err=1, data=0 exactly TIMEOUT cycles after WAIT entry.
REQ-036 Busy block: i_busy=1 with i_req=0010 -> no ack until i_busy falls; grant on next cycle.
REQ-037 Reset in WAIT: assert i_rst -> all outputs 0 immediately, no response; then i_req=1000 -> granted id=3.
REQ-038 Tie: i_data_valid on TIMEOUT cycle -> err=0, data=i_data_r.
